fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage; sits directly upstream of the instruction decoder.
- Holds the PC and issues word-aligned requests to instruction memory.
- Buffers in-order responses in a small FIFO and presents one 32-bit instruction plus its PC to decode over a valid/ready handshake.
- On a redirect (branch/jump resolved downstream) it flushes buffered and in-flight instructions and restarts at the new PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- FIFO_DEPTH, 4, instruction buffer entries; power of two, >= 2; also the max outstanding-plus-buffered count.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  32  request address (always [1:0]=0).
- imem_rsp_valid  input  1  response valid; responses return in request order, latency >= 1 cycle, never back-pressured.
- imem_rsp_data  input  32  fetched instruction word.
- redirect_valid  input  1  one-cycle pulse: restart fetch.
- redirect_pc  input  32  new PC; bits [1:0] are forced to 0.
- inst_valid  output  1  instruction available to decode.
- inst_ready  input  1  decode accepts instruction.
- inst  output  32  instruction word (FIFO head).
- inst_pc  output  32  PC of inst.

Behaviour:
- Reset (async assert, sync-release use):
  - pc=RESET_PC; FIFO empty; outstanding=0; state=FETCH.
  - imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0.
- Credit rule:
  - imem_req_valid=1 only when state==FETCH and fifo_count+outstanding < FIFO_DEPTH.
  - imem_req_addr=pc.
  - Request handshake (valid&ready): pc<=pc+4 (wraps mod 2^32); outstanding+1.
  - The PC of each request is queued internally alongside it (FIFO_DEPTH-entry PC queue) for inst_pc.
- Response:
  - In FETCH, each imem_rsp_valid pushes {data, pc} into the FIFO; outstanding-1.
  - Credit guarantees the FIFO is never full on push. Overflow is an assertion error.
- Output:
  - inst_valid = FIFO non-empty; inst/inst_pc = head, registered.
  - Pop on inst_valid&inst_ready.
  - Push and pop in the same cycle is allowed; count is unchanged.
  - Minimum latency: request accepted cycle N, response in N+1, inst_valid=1 in N+2.
- FSM states:
  - FETCH: normal operation.
  - DRAIN: discard returning responses of pre-redirect requests; no new requests.
- Redirect handling (redirect_valid=1, any state):
  - pc <= {redirect_pc[31:2],2'b00}.
  - FIFO flushed; inst_valid=0 next cycle.
  - An inst handshake in the same cycle still counts as consumed before the flush.
  - drop = outstanding + (req handshake this cycle) - (rsp_valid this cycle); a response in the same cycle is discarded.
  - If drop>0: state<=DRAIN, outstanding<=drop. Otherwise state<=FETCH.
- DRAIN:
  - Each imem_rsp_valid is discarded and decrements outstanding.
  - When outstanding reaches 0 (including on the cycle the last response arrives), go to FETCH.
  - The first request at the new pc is issued the following cycle.
  - A further redirect in DRAIN updates pc and stays in DRAIN with the recomputed count.
- No requests are issued in the redirect cycle itself.
- Counter widths: outstanding and fifo_count are $clog2(FIFO_DEPTH)+1 bits.

Test Plan:
- Reset, memory 1-cycle latency always ready, inst_ready=1 -> addrs 0x0,0x4,0x8,...; inst_pc matches each word; first inst_valid 2 cycles after the first request; 1 instruction/cycle sustained.
- inst_ready=0 for 10 cycles -> exactly 4 requests issued, FIFO holds words from 0x0..0xC in order, then imem_req_valid=0. Release -> order preserved, no loss or duplication.
- Memory latency 3 cycles, 3 requests in flight, redirect_pc=0x100 -> 3 responses discarded, inst_valid=0, first new request addr 0x100 only after the 3rd old response; first inst_pc=0x100.
- Redirect to 0x203 in the same cycle as a response and an inst handshake -> response dropped, handshaked inst counted once, next fetch addr 0x200.
- Back-to-back redirects 0x40 then 0x80 during DRAIN -> only 0x80 stream delivered; no 0x40 instruction appears.
- pc=0xFFFF_FFFC fetch -> next request addr 0x0000_0000 (wrap); rst_n asserted mid-DRAIN -> all outputs 0 immediately, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-aligned requests to
// instruction memory, buffers in-order responses and hands one instruction
// plus its PC to decode. A redirect flushes buffered work, drains in-flight
// responses and restarts fetch at the new PC.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    state_e state;
    state_e state_next;

    // Architectural state
    logic [31:0]      pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] fifo_count;

    // PC of every request still waiting for its response, in issue order
    logic [31:0]      pcq_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] pcq_wr_ptr;
    logic [PTR_W-1:0] pcq_rd_ptr;

    // Instruction buffer towards decode
    logic [31:0]      fifo_inst [FIFO_DEPTH];
    logic [31:0]      fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0] fifo_wr_ptr;
    logic [PTR_W-1:0] fifo_rd_ptr;

    // Per-cycle events and next-state values
    logic             req_fire;
    logic             inst_fire;
    logic             rsp_push;
    logic [31:0]      rsp_pc;
    logic [31:0]      pc_next;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] fifo_left;
    logic [CNT_W-1:0] fifo_count_next;
    logic [PTR_W-1:0] head_ptr;
    logic [SUM_W-1:0] credit_used;
    logic             req_valid_next;
    logic             inst_valid_next;
    logic [31:0]      inst_next;
    logic [31:0]      inst_pc_next;

    // Handshakes, counters and PC update for this cycle
    always_comb begin
        req_fire  = imem_req_valid && imem_req_ready;
        inst_fire = inst_valid && inst_ready;
        // Responses are only kept in FETCH and never in a redirect cycle
        rsp_push  = imem_rsp_valid && (state == ST_FETCH) && !redirect_valid;
        rsp_pc    = pcq_mem[pcq_rd_ptr];

        // Every response retires one in-flight request, kept or discarded
        outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

        // A pop in the redirect cycle is consumed before the flush
        fifo_left = fifo_count - CNT_W'(inst_fire);
        if (redirect_valid) begin
            fifo_count_next = '0;
        end else begin
            fifo_count_next = fifo_left + CNT_W'(rsp_push);
        end
        head_ptr = fifo_rd_ptr + PTR_W'(inst_fire);

        pc_next = pc;
        if (redirect_valid) begin
            pc_next = redirect_pc & 32'hFFFF_FFFC;
        end else if (req_fire) begin
            pc_next = pc + 32'd4;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: drain whenever a redirect leaves requests in flight
    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = (outstanding_next != '0) ? ST_DRAIN : ST_FETCH;
        end else if ((state == ST_DRAIN) && (outstanding_next == '0)) begin
            state_next = ST_FETCH;
        end
    end

    // Output values for the next cycle: request credit and FIFO head
    always_comb begin
        credit_used     = SUM_W'(fifo_count_next) + SUM_W'(outstanding_next);
        req_valid_next  = (state_next == ST_FETCH) && (credit_used < SUM_W'(FIFO_DEPTH));
        inst_valid_next = (fifo_count_next != '0);
        inst_next       = inst;
        inst_pc_next    = inst_pc;
        if (inst_valid_next) begin
            if (fifo_left == '0) begin
                // Buffer was empty after any pop: the new response becomes head
                inst_next    = imem_rsp_data;
                inst_pc_next = rsp_pc;
            end else begin
                inst_next    = fifo_inst[head_ptr];
                inst_pc_next = fifo_pc[head_ptr];
            end
        end
    end

    // PC, counters, pointers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            outstanding    <= '0;
            fifo_count     <= '0;
            pcq_wr_ptr     <= '0;
            pcq_rd_ptr     <= '0;
            fifo_wr_ptr    <= '0;
            fifo_rd_ptr    <= '0;
            imem_req_valid <= 1'b0;
            inst_valid     <= 1'b0;
            inst           <= '0;
            inst_pc        <= '0;
        end else begin
            pc          <= pc_next;
            outstanding <= outstanding_next;
            fifo_count  <= fifo_count_next;
            pcq_wr_ptr  <= pcq_wr_ptr + PTR_W'(req_fire);
            pcq_rd_ptr  <= pcq_rd_ptr + PTR_W'(imem_rsp_valid);
            if (redirect_valid) begin
                fifo_wr_ptr <= '0;
                fifo_rd_ptr <= '0;
            end else begin
                fifo_wr_ptr <= fifo_wr_ptr + PTR_W'(rsp_push);
                fifo_rd_ptr <= head_ptr;
            end
            imem_req_valid <= req_valid_next;
            inst_valid     <= inst_valid_next;
            inst           <= inst_next;
            inst_pc        <= inst_pc_next;
        end
    end

    // Storage arrays; contents are only read behind valid pointers
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq_mem[pcq_wr_ptr] <= pc;
        end
        if (rsp_push) begin
            fifo_inst[fifo_wr_ptr] <= imem_rsp_data;
            fifo_pc[fifo_wr_ptr]   <= rsp_pc;
        end
    end

    assign imem_req_addr = pc;

    // Credit must keep the buffer from overflowing and responses matched
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (rsp_push) begin
                assert (fifo_count < CNT_W'(FIFO_DEPTH));
            end
            if (imem_rsp_valid) begin
                assert (outstanding != '0);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected request addresses
// and expected (pc, word) pairs; monitors compare on each DUT handshake.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_inst_t;

    pend_t       pend[$];
    logic [31:0] exp_addr[$];
    exp_inst_t   exp_inst[$];

    int n_cmp = 0;
    int n_err = 0;
    int lat = 1;
    int cyc = 0;
    int n_req_hs = 0;
    int n_inst_hs = 0;
    int t_first_req = -1;
    int t_first_inst = -1;

    logic        m_hs;
    logic [31:0] m_addr;
    logic [31:0] mon_addr;
    exp_inst_t   mon_inst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: fixed latency, in-order, one response per cycle
    always begin
        @(negedge clk);
        m_hs   = rst_n && imem_req_valid && imem_req_ready;
        m_addr = imem_req_addr;
        @(posedge clk);
        cyc++;
        #1;
        if (!rst_n) begin
            pend.delete();
            imem_rsp_valid = 1'b0;
        end else begin
            if (m_hs) pend.push_back('{due: cyc + lat - 1, addr: m_addr});
            if (pend.size() > 0 && pend[0].due == cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    end

    // Monitor: compare every request and every delivered instruction
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_req_valid && imem_req_ready) begin
                n_req_hs++;
                if (t_first_req < 0) t_first_req = cyc;
                if (exp_addr.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL req_addr: unexpected request %h, none expected", imem_req_addr);
                end else begin
                    mon_addr = exp_addr.pop_front();
                    check("req_addr", imem_req_addr, mon_addr);
                end
            end
            if (inst_valid && t_first_inst < 0) t_first_inst = cyc;
            if (inst_valid && inst_ready) begin
                n_inst_hs++;
                if (exp_inst.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL inst: unexpected inst pc %h, none expected", inst_pc);
                end else begin
                    mon_inst = exp_inst.pop_front();
                    check("inst_pc", inst_pc, mon_inst.pc);
                    check("inst", inst, mon_inst.data);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_addr(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_addr.push_back(base + 32'(4 * i));
    endtask

    task automatic push_both(input logic [31:0] base, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 32'(4 * i);
            exp_addr.push_back(a);
            exp_inst.push_back('{pc: a, data: mem_word(a)});
        end
    endtask

    // Asynchronous reset with immediate output checks; leaves bench in cycle C0
    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        check("rst req_valid", 32'(imem_req_valid), 32'd0);
        check("rst req_addr", imem_req_addr, 32'h0000_0000);
        check("rst inst_valid", 32'(inst_valid), 32'd0);
        check("rst inst", inst, 32'h0);
        check("rst inst_pc", inst_pc, 32'h0);
        tick(2);
        exp_addr.delete();
        exp_inst.delete();
        n_req_hs     = 0;
        n_inst_hs    = 0;
        t_first_req  = -1;
        t_first_inst = -1;
        rst_n        = 1'b1;
    endtask

    // Stop requesting, drain everything, then every request must have been delivered
    task automatic quiesce(input string tag);
        int idle;
        idle = 0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        for (int i = 0; i < 60 && idle < 3; i++) begin
            tick(1);
            if (pend.size() == 0 && !inst_valid) idle++;
            else idle = 0;
        end
        check({tag, " drained"}, 32'(idle >= 3), 32'd1);
        check({tag, " leftover"}, 32'(exp_addr.size()), 32'(exp_inst.size()));
        exp_addr.delete();
        exp_inst.delete();
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        #2;

        // T1: streaming, 1-cycle memory
        do_reset();
        lat = 1;
        push_both(32'h0, 40);
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        tick(10);
        begin
            int mark;
            mark = n_inst_hs;
            tick(10);
            check("T1 throughput", 32'(n_inst_hs - mark), 32'd10);
        end
        check("T1 first latency", 32'(t_first_inst - t_first_req), 32'd2);
        quiesce("T1");

        // T2: decode stalled, credit limits requests to the FIFO depth
        do_reset();
        lat = 1;
        push_both(32'h0, 40);
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        tick(10);
        check("T2 req count", 32'(n_req_hs), 32'd4);
        check("T2 req_valid", 32'(imem_req_valid), 32'd0);
        check("T2 inst_valid", 32'(inst_valid), 32'd1);
        check("T2 head pc", inst_pc, 32'h0000_0000);
        check("T2 head word", inst, 32'hA5A5_5A5A);
        inst_ready = 1'b1;
        tick(10);
        quiesce("T2");

        // T3: redirect with three requests in flight, 3-cycle memory
        do_reset();
        lat = 3;
        push_addr(32'h0, 3);
        push_both(32'h100, 40);
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        tick(4);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick(1);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        check("T3 drain req_valid a", 32'(imem_req_valid), 32'd0);
        check("T3 flush inst_valid", 32'(inst_valid), 32'd0);
        tick(1);
        check("T3 drain req_valid b", 32'(imem_req_valid), 32'd0);
        tick(1);
        check("T3 restart req_valid", 32'(imem_req_valid), 32'd1);
        check("T3 restart addr", imem_req_addr, 32'h0000_0100);
        tick(10);
        quiesce("T3");

        // T4: redirect coincides with a response and an inst handshake
        do_reset();
        lat = 1;
        push_both(32'h0, 4);
        push_addr(32'h10, 2);
        push_both(32'h200, 40);
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        tick(6);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        tick(1);
        redirect_valid = 1'b0;
        check("T4 flush inst_valid", 32'(inst_valid), 32'd0);
        check("T4 drain req_valid", 32'(imem_req_valid), 32'd0);
        tick(1);
        check("T4 restart req_valid", 32'(imem_req_valid), 32'd1);
        check("T4 restart addr", imem_req_addr, 32'h0000_0200);
        check("T4 consumed once", 32'(n_inst_hs), 32'd4);
        tick(10);
        quiesce("T4");

        // T5: second redirect while draining
        do_reset();
        lat = 3;
        push_addr(32'h0, 3);
        push_both(32'h80, 40);
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        tick(4);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick(1);
        redirect_pc    = 32'h80;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        tick(1);
        redirect_valid = 1'b0;
        check("T5 drain req_valid", 32'(imem_req_valid), 32'd0);
        tick(1);
        check("T5 restart req_valid", 32'(imem_req_valid), 32'd1);
        check("T5 restart addr", imem_req_addr, 32'h0000_0080);
        tick(10);
        quiesce("T5");

        // T6: PC wraps past the top of the address space
        do_reset();
        lat = 1;
        push_both(32'hFFFF_FFF8, 40);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        tick(1);
        redirect_valid = 1'b0;
        check("T6 first addr", imem_req_addr, 32'hFFFF_FFF8);
        tick(2);
        check("T6 wrap req_valid", 32'(imem_req_valid), 32'd1);
        check("T6 wrap addr", imem_req_addr, 32'h0000_0000);
        check("T6 first inst_pc", inst_pc, 32'hFFFF_FFF8);
        tick(10);
        quiesce("T6");

        // T7: reset asserted while draining, then restart at the reset PC
        do_reset();
        lat = 3;
        push_addr(32'h0, 3);
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        tick(4);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick(1);
        redirect_valid = 1'b0;
        do_reset();
        lat = 1;
        push_both(32'h0, 40);
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        tick(1);
        check("T7 restart req_valid", 32'(imem_req_valid), 32'd1);
        check("T7 restart addr", imem_req_addr, 32'h0000_0000);
        tick(10);
        quiesce("T7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, %0d compared so far", n_cmp);
        $fatal(1);
    end

endmodule
